// File: rtl/clock_display_scan.sv
// Snapshots the H/M/S time bus once per frame and converts each field to BCD by subtracting 10 repeatedly.
// Scans the result onto a 6-digit multiplexed 7-segment display, HH.MM.SS.
module clock_display_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic [5:0] H,
    input  logic [5:0] M,
    input  logic [5:0] S,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic [5:0] An,
    output logic       Frame
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};
    localparam logic [5:0] AN_POL = {6{ACTIVE_LOW}};

    typedef enum logic [2:0] {IDLE, SNAP, DIV_H, DIV_M, DIV_S, COMMIT} state_t;

    state_t state_q, state_d;

    logic [PW-1:0] pre_q;
    logic [2:0] idx_q, idx_d;
    logic wrap;

    logic [5:0] h_q, m_q, s_q;
    logic [3:0] th_q, tm_q, ts_q;
    logic inv_h_q, inv_m_q, inv_s_q;

    logic [3:0] dh1_q, dh0_q, dm1_q, dm0_q, ds1_q, ds0_q;
    logic dinv_h_q, dinv_m_q, dinv_s_q, dsec_q;

    logic [6:0] seg_q, seg_d;
    logic [5:0] an_q, an_d;
    logic dp_q, dp_d;
    logic frame_q, frame_d;

    logic snap_en, commit_en, sub_h, sub_m, sub_s;
    logic [3:0] dig;
    logic dash;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0: r = 7'h3F;
            4'd1: r = 7'h06;
            4'd2: r = 7'h5B;
            4'd3: r = 7'h4F;
            4'd4: r = 7'h66;
            4'd5: r = 7'h6D;
            4'd6: r = 7'h7D;
            4'd7: r = 7'h07;
            4'd8: r = 7'h7F;
            4'd9: r = 7'h6F;
            default: r = 7'h00;
        endcase
        return r;
    endfunction

    assign wrap = (pre_q == PRE_MAX);
    assign idx_d = !wrap ? idx_q :
                   (idx_q == 3'd0) ? 3'd5 : idx_q - 3'd1;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            pre_q <= '0;
            idx_q <= 3'd5;
        end else begin
            pre_q <= wrap ? '0 : pre_q + 1'b1;
            idx_q <= idx_d;
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) state_q <= SNAP;
        else     state_q <= state_d;
    end

    // A new frame begins when the scan wraps from index 0 back to index 5
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (wrap && idx_q == 3'd0) state_d = SNAP;
            SNAP:   state_d = DIV_H;
            DIV_H:  if (inv_h_q || h_q < 6'd10) state_d = DIV_M;
            DIV_M:  if (inv_m_q || m_q < 6'd10) state_d = DIV_S;
            DIV_S:  if (inv_s_q || s_q < 6'd10) state_d = COMMIT;
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        snap_en   = 1'b0;
        commit_en = 1'b0;
        sub_h     = 1'b0;
        sub_m     = 1'b0;
        sub_s     = 1'b0;
        unique case (state_q)
            SNAP:   snap_en = 1'b1;
            DIV_H:  sub_h = !inv_h_q && (h_q >= 6'd10);
            DIV_M:  sub_m = !inv_m_q && (m_q >= 6'd10);
            DIV_S:  sub_s = !inv_s_q && (s_q >= 6'd10);
            COMMIT: commit_en = 1'b1;
            default: ;
        endcase
        frame_d = (state_d == COMMIT);
    end

    // Working registers end each division holding the ones digit
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            h_q <= '0;
            m_q <= '0;
            s_q <= '0;
            th_q <= '0;
            tm_q <= '0;
            ts_q <= '0;
            inv_h_q <= 1'b0;
            inv_m_q <= 1'b0;
            inv_s_q <= 1'b0;
        end else if (snap_en) begin
            h_q <= H;
            m_q <= M;
            s_q <= S;
            th_q <= '0;
            tm_q <= '0;
            ts_q <= '0;
            inv_h_q <= (H >= 6'd24);
            inv_m_q <= (M >= 6'd60);
            inv_s_q <= (S >= 6'd60);
        end else begin
            if (sub_h) begin
                h_q <= h_q - 6'd10;
                th_q <= th_q + 4'd1;
            end
            if (sub_m) begin
                m_q <= m_q - 6'd10;
                tm_q <= tm_q + 4'd1;
            end
            if (sub_s) begin
                s_q <= s_q - 6'd10;
                ts_q <= ts_q + 4'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            dh1_q <= '0;
            dh0_q <= '0;
            dm1_q <= '0;
            dm0_q <= '0;
            ds1_q <= '0;
            ds0_q <= '0;
            dinv_h_q <= 1'b0;
            dinv_m_q <= 1'b0;
            dinv_s_q <= 1'b0;
            dsec_q <= 1'b0;
        end else if (commit_en) begin
            dh1_q <= th_q;
            dh0_q <= h_q[3:0];
            dm1_q <= tm_q;
            dm0_q <= m_q[3:0];
            ds1_q <= ts_q;
            ds0_q <= s_q[3:0];
            dinv_h_q <= inv_h_q;
            dinv_m_q <= inv_m_q;
            dinv_s_q <= inv_s_q;
            dsec_q <= s_q[0];
        end
    end

    always_comb begin
        dig  = 4'd0;
        dash = 1'b0;
        case (idx_d)
            3'd5: begin dig = dh1_q; dash = dinv_h_q; end
            3'd4: begin dig = dh0_q; dash = dinv_h_q; end
            3'd3: begin dig = dm1_q; dash = dinv_m_q; end
            3'd2: begin dig = dm0_q; dash = dinv_m_q; end
            3'd1: begin dig = ds1_q; dash = dinv_s_q; end
            default: begin dig = ds0_q; dash = dinv_s_q; end
        endcase
        seg_d = dash ? 7'h40 : seg7(dig);
        an_d  = 6'b000001 << idx_d;
        dp_d  = (idx_d == 3'd4 || idx_d == 3'd2) && !dsec_q;
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            seg_q   <= SEG_POL;
            an_q    <= AN_POL;
            dp_q    <= ACTIVE_LOW;
            frame_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            if (wrap) begin
                seg_q <= seg_d ^ SEG_POL;
                an_q  <= an_d ^ AN_POL;
                dp_q  <= dp_d ^ ACTIVE_LOW;
            end
        end
    end

    assign Seg   = seg_q;
    assign An    = an_q;
    assign Dp    = dp_q;
    assign Frame = frame_q;
endmodule

// File: tb/tb_clock_display_scan.sv
// Randomized bench for clock_display_scan with a frame-level reference model.
// A second instance covers the inverted output polarity.
module tb_clock_display_scan;
    localparam int SD = 32;
    localparam int FR = 6 * SD;

    logic clk = 1'b0;
    logic clr, clr2;
    logic [5:0] h, m, s;
    logic [6:0] seg, seg2;
    logic [5:0] an, an2;
    logic dp, dp2, frame, frame2;

    int n_run = 0;
    int n_fail = 0;
    int n = 0;
    logic chk_en = 1'b0;
    logic [5:0] sh [16];
    logic [5:0] sm [16];
    logic [5:0] ss [16];
    logic [6:0] segs [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    clock_display_scan #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b0)) dut (
        .Clk(clk), .Clr(clr), .H(h), .M(m), .S(s),
        .Seg(seg), .Dp(dp), .An(an), .Frame(frame)
    );

    clock_display_scan #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) dut_al (
        .Clk(clk), .Clr(clr2), .H(6'd0), .M(6'd0), .S(6'd1),
        .Seg(seg2), .Dp(dp2), .An(an2), .Frame(frame2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, n);
        end
    endtask

    // Edges since Clr fell; the frame-k snapshot is taken at edge k*FR+1
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            n <= 0;
        end else begin
            if ((n + 1) % FR == 1) begin
                sh[((n + 1) / FR) % 16] <= h;
                sm[((n + 1) / FR) % 16] <= m;
                ss[((n + 1) / FR) % 16] <= s;
            end
            n <= n + 1;
        end
    end

    function automatic int fval(int k, int f);
        if (f == 2) return int'(sh[k % 16]);
        if (f == 1) return int'(sm[k % 16]);
        return int'(ss[k % 16]);
    endfunction

    function automatic int flim(int f);
        return (f == 2) ? 24 : 60;
    endfunction

    function automatic logic [6:0] exp_seg(int k, int idx);
        int f, v;
        f = idx / 2;
        v = fval(k, f);
        if (v >= flim(f)) return 7'h40;
        return (idx % 2 == 1) ? segs[v / 10] : segs[v % 10];
    endfunction

    function automatic int cost(int k);
        int c = 0;
        for (int f = 0; f < 3; f++) begin
            int v = fval(k, f);
            c += (v >= flim(f)) ? 1 : v / 10 + 1;
        end
        return c;
    endfunction

    task automatic check_cycle();
        int w, idx, k, kf;
        logic [5:0] ea;
        logic [6:0] es;
        logic ed, ef;
        ea = '0;
        es = '0;
        ed = 1'b0;
        ef = 1'b0;
        w = n / SD;
        if (w > 0) begin
            idx = 5 - (w % 6);
            k = (w - 1) / 6;
            ea = 6'(1 << idx);
            es = exp_seg(k, idx);
            ed = (idx == 4 || idx == 2) && (ss[k % 16][0] == 1'b0);
        end
        if (n >= 1) begin
            kf = (n - 1) / FR;
            ef = (n == kf * FR + 1 + cost(kf));
        end
        chk("an", an, ea);
        chk("seg", seg, es);
        chk("dp", dp, ed);
        chk("frame", frame, ef);
    endtask

    always begin
        @(posedge clk);
        #2;
        if (chk_en) check_cycle();
    end

    task automatic wait_n(input int t);
        int i = 0;
        while (n != t && i < 5000) begin
            @(negedge clk);
            i++;
        end
        if (n != t) chk("wait_n", n, t);
    endtask

    function automatic logic [5:0] rnd(int lim);
        if ($urandom_range(0, 3) == 0) return 6'($urandom_range(0, 63));
        return 6'($urandom_range(0, lim - 1));
    endfunction

    initial begin
        clr = 1'b1;
        clr2 = 1'b1;
        h = 6'd12;
        m = 6'd34;
        s = 6'd56;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("al_an_rst", an2, 6'h3F);
        chk("al_seg_rst", seg2, 7'h7F);
        chk("al_dp_rst", dp2, 1'b1);
        chk("al_frame_rst", frame2, 1'b0);
        clr = 1'b0;
        clr2 = 1'b0;
        repeat (SD - 1) @(negedge clk);
        chk("al_an_pre", an2, 6'h3F);
        @(negedge clk);
        chk("al_an_i4", an2, 6'b101111);
        chk("al_seg_i4", seg2, 7'h40);
        chk("al_dp_i4", dp2, 1'b1);

        wait_n(2 * FR + 8);
        h = 6'd23;
        m = 6'd59;
        s = 6'd59;
        wait_n(4 * FR + 8);
        h = 6'd30;
        m = 6'd5;
        s = 6'd60;
        wait_n(6 * FR + 8);
        h = 6'd10;
        m = 6'd34;
        s = 6'd56;
        wait_n(7 * FR + 4);
        h = 6'd11;
        wait_n(9 * FR + 8);
        h = 6'd12;
        wait_n(10 * FR + 8);
        clr = 1'b1;
        #1;
        chk("clr_an", an, 6'h00);
        chk("clr_frame", frame, 1'b0);
        chk("clr_seg", seg, 7'h00);
        repeat (3) @(negedge clk);
        clr = 1'b0;
        wait_n(FR + 40);

        for (int it = 0; it < 24; it++) begin
            h = rnd(24);
            m = rnd(60);
            s = rnd(60);
            repeat ($urandom_range(30, 400)) @(negedge clk);
        end
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
